// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared scan states, off-drive constants and the hex-to-segment table.
package seven_seg_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is the leftmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low 7-segment pattern.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: four-digit common-anode scan with inter-digit blanking gap.
// Next-state values drive the output registers so an, seg and dp always switch together.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t        state, nxt_state;
    logic [PW-1:0] pre, nxt_pre;
    logic [7:0]    gap, nxt_gap;
    logic [1:0]    sel, nxt_sel;
    logic [15:0]   sh_digits, nxt_digits;
    logic [3:0]    sh_dp, nxt_dp;
    logic [3:0]    sh_blank, nxt_blank;
    logic          latch;
    logic          lit;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;

    always_comb begin
        nxt_state = state;
        nxt_pre   = pre;
        nxt_gap   = gap;
        nxt_sel   = sel;
        latch     = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_pre   = '0;
            nxt_gap   = '0;
            nxt_sel   = '0;
        end else if (state == IDLE) begin
            nxt_state = SHOW;
            latch     = 1'b1;
        end else if (state == SHOW) begin
            nxt_pre = pre + 1'b1;
            if (pre == PRE_LAST) begin
                nxt_pre = '0;
                if (GAP_CYCLES > 0) begin
                    nxt_state = GAP;
                end else begin
                    nxt_sel = sel + 1'b1;
                    latch   = (sel == 2'd3);
                end
            end
        end else begin
            nxt_gap = gap + 1'b1;
            if (gap == GAP_LAST) begin
                nxt_gap   = '0;
                nxt_state = SHOW;
                nxt_sel   = sel + 1'b1;
                latch     = (sel == 2'd3);
            end
        end
        nxt_digits = latch ? digits : sh_digits;
        nxt_dp     = latch ? dp_in : sh_dp;
        nxt_blank  = latch ? blank_mask : sh_blank;
        nibble     = nxt_digits[{nxt_sel, 2'b00} +: 4];
        lit        = (nxt_state == SHOW) && !nxt_blank[nxt_sel];
    end

    hex_to_seg u_dec (
        .nibble(nibble),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pre       <= '0;
            gap       <= '0;
            sel       <= '0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            state     <= nxt_state;
            pre       <= nxt_pre;
            gap       <= nxt_gap;
            sel       <= nxt_sel;
            sh_digits <= nxt_digits;
            sh_dp     <= nxt_dp;
            sh_blank  <= nxt_blank;
            an        <= lit ? ~(4'b0001 << nxt_sel) : AN_OFF;
            seg       <= lit ? dec_seg : SEG_OFF;
            dp        <= lit ? ~nxt_dp[nxt_sel] : 1'b1;
        end
    end

    assign digit_sel = sel;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: random stimulus against a frame-position model, with and without gap.
module tb_seven_seg_scan_ctrl;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [1:0] sel_a, sel_b;

    int checks = 0;
    int failures = 0;

    // Instance 0 has a one-cycle gap, instance 1 has none.
    int          t [2];
    logic [15:0] md [2];
    logic [3:0]  mdp [2];
    logic [3:0]  mbl [2];

    logic [6:0] segt [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.REFRESH_DIV(R), .GAP_CYCLES(1)) dut_gap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .digits(digits),
        .dp_in(dp_in), .blank_mask(blank_mask),
        .an(an_a), .seg(seg_a), .dp(dp_a), .digit_sel(sel_a)
    );

    seven_seg_scan_ctrl #(.REFRESH_DIV(R), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .digits(digits),
        .dp_in(dp_in), .blank_mask(blank_mask),
        .an(an_b), .seg(seg_b), .dp(dp_b), .digit_sel(sel_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t[i] = -1;
            md[i] = '0;
            mdp[i] = '0;
            mbl[i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!enable) begin
                t[i] = -1;
            end else begin
                t[i] = (t[i] < 0) ? 0 : t[i] + 1;
                if (t[i] % (4 * (R + gap_of(i))) == 0) begin
                    md[i] = digits;
                    mdp[i] = dp_in;
                    mbl[i] = blank_mask;
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            int slot_len, pos, slot;
            logic lit;
            logic [3:0] ea;
            logic [6:0] es;
            logic ed;
            slot_len = R + gap_of(i);
            pos = (t[i] < 0) ? 0 : t[i] % (4 * slot_len);
            slot = pos / slot_len;
            lit = (t[i] >= 0) && (pos % slot_len < R) && !mbl[i][slot];
            ea = lit ? (4'hF ^ (4'b0001 << slot)) : 4'hF;
            es = lit ? segt[md[i][slot*4 +: 4]] : 7'h7F;
            ed = lit ? ~mdp[i][slot] : 1'b1;
            check($sformatf("an%0d", i), i ? an_b : an_a, ea);
            check($sformatf("seg%0d", i), i ? seg_b : seg_a, es);
            check($sformatf("dp%0d", i), i ? dp_b : dp_a, ed);
            check($sformatf("sel%0d", i), i ? sel_b : sel_a, slot);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1 compare();
        @(negedge clk);
        reset_n = 1'b1;
        compare();

        digits = 16'h3210;
        enable = 1'b1;
        for (int k = 0; k < 7; k++) step();
        digits = 16'hFEDC;
        for (int k = 0; k < 38; k++) step();

        blank_mask = 4'b0100;
        dp_in = 4'b0001;
        for (int k = 0; k < 45; k++) step();

        for (int k = 0; k < 12 && (t[0] % (R + 1) != R); k++) step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        digits = 16'h9A5B;
        blank_mask = 4'b0000;
        for (int k = 0; k < 25; k++) step();

        for (int k = 0; k < 600; k++) begin
            enable = ($urandom_range(39) != 0);
            if ($urandom_range(3) == 0) digits = 16'($urandom);
            if ($urandom_range(7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(7) == 0) blank_mask = 4'($urandom_range(15) & $urandom_range(15));
            step();
        end

        enable = 1'b1;
        for (int k = 0; k < 7; k++) step();
        @(posedge clk);
        model_edge();
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        reset_n = 1'b1;
        digits = 16'h0F1E;
        for (int k = 0; k < 30; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing controller for the Basys3 four-digit common-anode 7-segment display. It owns the scan sequence: a refresh prescaler, a 2-bit digit-select counter, and a blanking gap between digits to suppress ghosting. Each 4-bit hex nibble is decoded to active-low segment drive. It sits between the design's value registers and the board pins (`an`, `seg`, `dp`), and presents a tear-free frame by latching the input value once per scan frame.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit is lit; legal range 2..2^20.
- `GAP_CYCLES`, 16: blank cycles between digits, with all anodes off; legal range 0..255.
- `clk` in 1: system clock, 100 MHz on board.
- `reset_n` in 1: asynchronous, active-low reset (one clock; reset asynchronous, active-low).
- `enable` in 1: scan enable; when low the display is dark.
- `digits` in 16: four hex nibbles; digit k is `digits[4k+3:4k]`.
- `dp_in` in 4: decimal point request per digit, active high.
- `blank_mask` in 4: per-digit blank, active high.
- `an` out 4: anode drive, active low; `an[k]` lights digit k.
- `seg` out 7: segment drive, active low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point drive, active low.
- `digit_sel` out 2: index of the current or next digit slot.

## Operation
- States: IDLE, SHOW, GAP.
- **IDLE**
  - Outputs: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `digit_sel`=0, prescaler=0.
  - `enable`=1 → SHOW with `digit_sel`=0. The same edge latches `digits`, `dp_in` and `blank_mask` into shadow registers.
- **SHOW**
  - Drives the decoded shadow nibble for `digit_sel` and `dp`=~shadow_dp[sel].
  - Drives `an` one-hot low at `digit_sel`, unless shadow_blank[sel]=1. A blanked slot is still consumed: `an`=1111, `seg`=7F, `dp`=1.
  - Prescaler counts 0..REFRESH_DIV-1. At the terminal count:
    - GAP_CYCLES>0 → GAP.
    - GAP_CYCLES=0 → advance `digit_sel` and stay in SHOW.
- **GAP**
  - Outputs are all off; a separate counter runs 0..GAP_CYCLES-1.
  - At the terminal count: `digit_sel` increments mod 4 and the state returns to SHOW.
- **Frame latch**
  - Occurs when `digit_sel` wraps 3→0, and on IDLE→SHOW.
  - Shadow ← {`digits`, `dp_in`, `blank_mask`}.
  - Input changes mid-frame have no effect until the next frame.
- **Disable**
  - `enable`=0 in any state → IDLE on the next edge; outputs are dark that same cycle.
  - Counters are cleared and `digit_sel`=0.
- **Hex decode** (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Reset**
  - Asynchronous assertion forces IDLE, all counters 0, shadow 0.
  - Outputs: `an`=1111, `seg`=7F, `dp`=1, `digit_sel`=0.
  - Mid-scan reset takes effect immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; a state or digit change is visible one cycle after the deciding edge.
- From enable sampled high to the first lit digit (digit 0): 1 cycle.
- Digit slot: REFRESH_DIV lit cycles followed by GAP_CYCLES dark cycles.
- Frame period: 4·(REFRESH_DIV+GAP_CYCLES) cycles.
- At most one `an` bit is low in any cycle, and it is never low in GAP or IDLE.
- `an` and `seg` change on the same edge. A new digit never appears with the old segments.
- Prescaler width: clog2(REFRESH_DIV). Gap counter: 8 bits.

## Structure
- Package `seven_seg_pkg`:
  - state enum {IDLE, SHOW, GAP}
  - constants `SEG_OFF`=7'h7F, `AN_OFF`=4'hF
  - the 16-entry hex-to-segment constant table
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit active-low decoder, using the package table. Its output is registered in the parent.
- The parent holds the FSM, both counters, the shadow registers and the output registers.

## Test plan
All scenarios use REFRESH_DIV=4 and GAP_CYCLES=1.
- **Reset:** hold `reset_n`=0 mid-scan → `an`=1111, `seg`=7F, `dp`=1, `digit_sel`=0 immediately, with no clock edge.
- **Scan:** `digits`=16'h3210, `enable`=1 → repeating `an` sequence 1110×4, 1111×1, 1101×4, 1111×1, 1011×4, 1111×1, 0111×4, 1111×1. `seg` per lit slot = 1000000, 1111001, 0100100, 0110000. Frame = 20 cycles.
- **Frame latch:** change `digits` to 16'hFEDC during digit 1 → the current frame still shows 2 and 3; the next frame shows C, d, E, F (0001110 on digit 3).
- **Blank / DP:** `blank_mask`=4'b0100, `dp_in`=4'b0001 → digit 2 slot keeps `an`=1111 for its 4 cycles; `dp`=0 only while `an`=1110.
- **Disable:** drop `enable` during GAP → `an`=1111 next cycle, `digit_sel`=0. Re-enable → digit 0 lit 1 cycle later with freshly latched `digits`.
- **No gap:** GAP_CYCLES=0 → `an` goes directly 1110→1101 with no 1111 cycle; frame = 16 cycles.
